// File: rtl/jump_judge_pkg.sv
// jump_judge_pkg: shared state encoding and geometry constants for the jump game
package jump_judge_pkg;
  localparam int X_W = 10;
  localparam int STAGE0_X = 60;
  typedef enum logic [2:0] {IDLE, PLACE, READY, CHARGE, FLY, JUDGE, SCROLL, OVER} state_e;
endpackage

// File: rtl/jump_judge_if.sv
// jump_judge_if: game-control inputs and player/score outputs of the jump judge
interface jump_judge_if;
  import jump_judge_pkg::*;
  logic           enable;
  logic           press;
  logic [X_W-1:0] stage_x [2];
  logic [X_W-1:0] stage_w [2];
  logic [X_W-1:0] player_x;
  logic [X_W-1:0] player_y;
  logic [7:0]     charge;
  logic           next_stage;
  logic           hit;
  logic           game_over;
  logic [15:0]    score;
  modport master (output enable, press, stage_x, stage_w,
                  input player_x, player_y, charge, next_stage, hit, game_over, score);
  modport slave  (input enable, press, stage_x, stage_w,
                  output player_x, player_y, charge, next_stage, hit, game_over, score);
endinterface

// File: rtl/jump_judge_flight.sv
// jump_flight: steps player_x toward the clamped target and draws the triangular jump arc
module jump_flight
  import jump_judge_pkg::*;
#(
  parameter int STEP_DIV = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           go_i,
  input  logic           run_i,
  input  logic [X_W-1:0] start_i,
  input  logic [11:0]    target_i,
  output logic [X_W-1:0] x_o,
  output logic [X_W-1:0] y_o,
  output logic           done_o
);
  logic [X_W-1:0] x_q, start_q, end_q, y_q, x_n, d_n, y_n;
  logic [11:0]    span_q, rem_n;
  logic [15:0]    div_q;
  logic           step;
  assign step   = run_i & (div_q == 16'(STEP_DIV - 1));
  assign x_n    = x_q + 1'b1;
  assign d_n    = x_n - start_q;
  assign rem_n  = span_q - {2'b0, d_n};
  assign y_n    = ({2'b0, d_n} < rem_n) ? d_n : rem_n[X_W-1:0];
  assign done_o = step & (x_n == end_q);
  assign x_o    = x_q;
  assign y_o    = y_q;
  // load the flight on go, then advance one pixel every STEP_DIV cycles; height drops to 0 on arrival
  always_ff @(posedge clk) begin
    if (!rst) begin
      x_q     <= '0;
      start_q <= '0;
      end_q   <= '0;
      y_q     <= '0;
      span_q  <= '0;
      div_q   <= '0;
    end else if (go_i) begin
      x_q     <= start_i;
      start_q <= start_i;
      end_q   <= (target_i > 12'd1023) ? 10'd1023 : target_i[X_W-1:0];
      span_q  <= target_i - {2'b0, start_i};
      y_q     <= '0;
      div_q   <= '0;
    end else if (run_i) begin
      div_q <= step ? 16'd0 : div_q + 16'd1;
      if (step) begin
        x_q <= x_n;
        y_q <= done_o ? '0 : y_n;
      end
    end
  end
endmodule

// File: rtl/jump_judge.sv
// jump_judge: charge/jump FSM with landing judge, scoring and new-platform requests
module jump_judge
  import jump_judge_pkg::*;
#(
  parameter int GAIN_SHIFT = 1,
  parameter int CHARGE_MAX = 255,
  parameter int STEP_DIV   = 1
) (
  input logic         clk,
  input logic         rst,
  jump_judge_if.slave bus
);
  state_e         state_q;
  logic           press_q, rise, fall, go, done, hit_c, stay_c;
  logic [X_W-1:0] player_x_q, off_q, fx, fy, end_d;
  logic [7:0]     charge_q;
  logic [15:0]    score_q;
  logic [11:0]    target_q, tgt_d;
  assign rise   = bus.press & ~press_q;
  assign fall   = ~bus.press & press_q;
  assign tgt_d  = {2'b0, player_x_q} + ({4'b0, charge_q} << GAIN_SHIFT);
  assign end_d  = (tgt_d > 12'd1023) ? 10'd1023 : tgt_d[X_W-1:0];
  assign go     = (state_q == CHARGE) & fall;
  assign hit_c  = ({2'b0, bus.stage_x[1]} <= target_q) &
                  (target_q < {2'b0, bus.stage_x[1]} + {2'b0, bus.stage_w[1]});
  assign stay_c = target_q < {2'b0, bus.stage_x[0]} + {2'b0, bus.stage_w[0]};
  assign bus.player_x   = (state_q == FLY) ? fx : player_x_q;
  assign bus.player_y   = (state_q == FLY) ? fy : '0;
  assign bus.charge     = charge_q;
  assign bus.hit        = (state_q == JUDGE) & hit_c;
  assign bus.next_stage = bus.hit;
  assign bus.game_over  = state_q == OVER;
  assign bus.score      = score_q;
  jump_flight #(.STEP_DIV(STEP_DIV)) u_flight (
    .clk(clk), .rst(rst), .go_i(go), .run_i(state_q == FLY),
    .start_i(player_x_q), .target_i(tgt_d), .x_o(fx), .y_o(fy), .done_o(done)
  );
  // game FSM: place, charge, fly, judge the landing and scroll onto the new platform
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      press_q    <= 1'b0;
      player_x_q <= '0;
      charge_q   <= '0;
      score_q    <= '0;
      target_q   <= '0;
      off_q      <= '0;
    end else begin
      press_q <= bus.press;
      if (!bus.enable) begin
        state_q    <= IDLE;
        player_x_q <= '0;
        charge_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            score_q <= '0;
            state_q <= PLACE;
          end
          PLACE: begin
            player_x_q <= bus.stage_x[0] + (bus.stage_w[0] >> 1);
            state_q    <= READY;
          end
          READY: if (rise) begin
            charge_q <= '0;
            state_q  <= CHARGE;
          end
          CHARGE: begin
            if (fall) begin
              target_q <= tgt_d;
              state_q  <= (end_d == player_x_q) ? JUDGE : FLY;
            end else if (bus.press && charge_q < 8'(CHARGE_MAX)) charge_q <= charge_q + 8'd1;
          end
          FLY: if (done) begin
            player_x_q <= fx + 1'b1;
            state_q    <= JUDGE;
          end
          JUDGE: begin
            if (hit_c) begin
              score_q <= score_q + 16'd1;
              off_q   <= X_W'(target_q - {2'b0, bus.stage_x[1]});
              state_q <= SCROLL;
            end else state_q <= stay_c ? READY : OVER;
          end
          SCROLL: begin
            player_x_q <= bus.stage_x[0] + off_q;
            state_q    <= READY;
          end
          OVER: if (rise) begin
            score_q <= '0;
            state_q <= PLACE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_jump_judge.sv
// tb_jump_judge: directed scenarios for hit, stay, edges, miss, saturation, clamp and resets
module tb_jump_judge;
  logic clk = 0;
  logic rst = 0;
  int pass_cnt = 0;
  int total = 0;
  jump_judge_if bus();
  jump_judge #(.GAIN_SHIFT(1), .CHARGE_MAX(255), .STEP_DIV(1)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_stage(input int x0, input int w0, input int x1, input int w1);
    bus.stage_x[0] = 10'(x0);
    bus.stage_w[0] = 10'(w0);
    bus.stage_x[1] = 10'(x1);
    bus.stage_w[1] = 10'(w1);
  endtask

  // hold press so charge reaches n, release, then follow the flight to end_x and 3 more cycles
  task automatic jump(input int n, input int end_x, output int cyc, output int peak,
                      output int hits, output int nexts, output int chg, output int y0);
    bus.press = 1;
    repeat (n + 1) tick();
    chg = int'(bus.charge);
    bus.press = 0;
    tick();
    y0 = int'(bus.player_y);
    cyc = 0; peak = 0; hits = 0; nexts = 0;
    while (int'(bus.player_x) != end_x && cyc < 2000) begin
      tick();
      cyc++;
      if (int'(bus.player_y) > peak) peak = int'(bus.player_y);
      hits += int'(bus.hit);
      nexts += int'(bus.next_stage);
    end
    repeat (3) begin
      tick();
      hits += int'(bus.hit);
      nexts += int'(bus.next_stage);
    end
  endtask

  task automatic rise_release();
    bus.press = 1;
    tick();
    tick();
    bus.press = 0;
    tick();
  endtask

  task automatic test_reset();
    rst = 0; bus.enable = 0; bus.press = 0;
    set_stage(60, 60, 200, 40);
    repeat (3) tick();
    total++; if (bus.player_x !== 10'd0 || bus.player_y !== 10'd0 || bus.charge !== 8'd0) $display("FAIL reset_pos x=%0d y=%0d c=%0d required 0/0/0", bus.player_x, bus.player_y, bus.charge); else pass_cnt++;
    total++; if ({bus.hit, bus.next_stage, bus.game_over} !== 3'b000 || bus.score !== 16'd0) $display("FAIL reset_flags flags=%b score=%0d required 000/0", {bus.hit, bus.next_stage, bus.game_over}, bus.score); else pass_cnt++;
  endtask

  task automatic test_hit();
    int cyc, peak, hits, nexts, chg, y0;
    rst = 1; bus.enable = 1;
    tick();
    tick();
    total++; if (bus.player_x !== 10'd90) $display("FAIL place_x actual=%0d required=90", bus.player_x); else pass_cnt++;
    jump(60, 210, cyc, peak, hits, nexts, chg, y0);
    total++; if (chg != 60) $display("FAIL hit_charge actual=%0d required=60", chg); else pass_cnt++;
    total++; if (cyc != 120) $display("FAIL hit_fly_cycles actual=%0d required=120", cyc); else pass_cnt++;
    total++; if (peak != 60 || y0 != 0) $display("FAIL hit_arc peak=%0d y0=%0d required 60/0", peak, y0); else pass_cnt++;
    total++; if (hits != 1 || nexts != 1) $display("FAIL hit_pulses hit=%0d next=%0d required 1/1", hits, nexts); else pass_cnt++;
    total++; if (bus.score !== 16'd1 || bus.player_x !== 10'd70) $display("FAIL hit_scroll score=%0d x=%0d required 1/70", bus.score, bus.player_x); else pass_cnt++;
  endtask

  task automatic test_enable_drop();
    bus.press = 1;
    tick();
    tick();
    bus.enable = 0;
    tick();
    total++; if (bus.player_x !== 10'd0 || bus.charge !== 8'd0 || bus.score !== 16'd1) $display("FAIL en_drop x=%0d c=%0d score=%0d required 0/0/1", bus.player_x, bus.charge, bus.score); else pass_cnt++;
    bus.press = 0; bus.enable = 1;
    tick();
    tick();
    total++; if (bus.score !== 16'd0 || bus.player_x !== 10'd90) $display("FAIL en_restart score=%0d x=%0d required 0/90", bus.score, bus.player_x); else pass_cnt++;
  endtask

  task automatic test_stay_edge();
    int cyc, peak, hits, nexts, chg, y0;
    jump(10, 110, cyc, peak, hits, nexts, chg, y0);
    total++; if (hits != 0 || cyc != 20 || bus.game_over !== 1'b0 || bus.score !== 16'd0) $display("FAIL stay hits=%0d cyc=%0d go=%b score=%0d required 0/20/0/0", hits, cyc, bus.game_over, bus.score); else pass_cnt++;
    total++; if (bus.player_x !== 10'd110) $display("FAIL stay_x actual=%0d required=110", bus.player_x); else pass_cnt++;
    jump(45, 200, cyc, peak, hits, nexts, chg, y0);
    total++; if (hits != 1 || bus.score !== 16'd1 || bus.player_x !== 10'd60) $display("FAIL left_edge hits=%0d score=%0d x=%0d required 1/1/60", hits, bus.score, bus.player_x); else pass_cnt++;
  endtask

  task automatic test_miss();
    int cyc, peak, hits, nexts, chg, y0;
    jump(90, 240, cyc, peak, hits, nexts, chg, y0);
    total++; if (hits != 0 || bus.game_over !== 1'b1 || bus.score !== 16'd1 || bus.player_x !== 10'd240) $display("FAIL right_edge hits=%0d go=%b score=%0d x=%0d required 0/1/1/240", hits, bus.game_over, bus.score, bus.player_x); else pass_cnt++;
    rise_release();
    total++; if (bus.score !== 16'd0 || bus.player_x !== 10'd90 || bus.game_over !== 1'b0) $display("FAIL over_restart score=%0d x=%0d go=%b required 0/90/0", bus.score, bus.player_x, bus.game_over); else pass_cnt++;
  endtask

  task automatic test_saturation();
    int cyc, peak, hits, nexts, chg, y0;
    jump(400, 600, cyc, peak, hits, nexts, chg, y0);
    total++; if (chg != 255) $display("FAIL sat_charge actual=%0d required=255", chg); else pass_cnt++;
    total++; if (cyc != 510 || bus.game_over !== 1'b1 || bus.player_x !== 10'd600) $display("FAIL sat_miss cyc=%0d go=%b x=%0d required 510/1/600", cyc, bus.game_over, bus.player_x); else pass_cnt++;
  endtask

  task automatic test_clamp();
    int cyc, peak, hits, nexts, chg, y0;
    set_stage(580, 40, 900, 100);
    rise_release();
    total++; if (bus.player_x !== 10'd600) $display("FAIL clamp_place actual=%0d required=600", bus.player_x); else pass_cnt++;
    jump(255, 1023, cyc, peak, hits, nexts, chg, y0);
    total++; if (cyc != 423 || hits != 0 || bus.game_over !== 1'b1 || bus.player_x !== 10'd1023 || bus.player_y !== 10'd0) $display("FAIL clamp cyc=%0d hits=%0d go=%b x=%0d y=%0d required 423/0/1/1023/0", cyc, hits, bus.game_over, bus.player_x, bus.player_y); else pass_cnt++;
  endtask

  task automatic test_reset_in_fly();
    set_stage(60, 60, 200, 40);
    rise_release();
    bus.press = 1;
    repeat (21) tick();
    bus.press = 0;
    tick();
    repeat (5) tick();
    total++; if (bus.player_x !== 10'd95 || bus.player_y !== 10'd5) $display("FAIL fly_mid x=%0d y=%0d required 95/5", bus.player_x, bus.player_y); else pass_cnt++;
    rst = 0;
    tick();
    total++; if (bus.player_x !== 10'd0 || bus.player_y !== 10'd0 || bus.charge !== 8'd0 || bus.game_over !== 1'b0 || bus.hit !== 1'b0) $display("FAIL fly_reset x=%0d y=%0d c=%0d go=%b hit=%b required all 0", bus.player_x, bus.player_y, bus.charge, bus.game_over, bus.hit); else pass_cnt++;
    rst = 1;
  endtask

  initial begin
    test_reset();
    test_hit();
    test_enable_drop();
    test_stay_edge();
    test_miss();
    test_saturation();
    test_clamp();
    test_reset_in_fly();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/jump_judge.md
# jump_judge

Player-jump controller and landing judge for the jump game, directly downstream of `generate_stage`. It reads the two current platforms (`stage_x`, `stage_w`). It turns a button hold into a charge and animates the jump arc. It then judges the landing and either scores and requests a new platform pair, keeps the player on the current platform, or ends the game. Its `next_stage` output drives the `enable` input of `generate_stage`.

## Interface
- `GAIN_SHIFT`, default 1: jump distance = charge << GAIN_SHIFT pixels.
- `CHARGE_MAX`, default 255: charge saturation value, 8-bit.
- `STEP_DIV`, default 1: cycles per 1-pixel flight step, ≥1.
- `clk` input 1: sole clock; all logic on posedge.
- `rst` input 1: reset, synchronous, active-low.
- `enable` input 1: game running; low forces IDLE.
- `press` input 1: button level, already synchronous to `clk`.
- `stage_x[0:1]` input 10 each: platform left edges; [0] = current, [1] = next.
- `stage_w[0:1]` input 10 each: platform widths.
- `player_x` output 10: player horizontal position.
- `player_y` output 10: jump height above platform, 0 when grounded.
- `charge` output 8: current charge, for the power bar.
- `next_stage` output 1: one-cycle pulse requesting a new platform pair.
- `hit` output 1: one-cycle pulse on a successful landing.
- `game_over` output 1: level, high in OVER.
- `score` output 16: number of successful landings.

## Operation
- States: IDLE, PLACE, READY, CHARGE, FLY, JUDGE, SCROLL, OVER.
- Press edge: `press` is registered; rise = press & ~press_q, fall = ~press & press_q.
- IDLE: all outputs 0. When `enable`=1, go to PLACE and clear `score`.
- PLACE: player_x ← stage_x[0] + (stage_w[0]>>1). Go to READY.
- READY: on rise, go to CHARGE with charge ← 0.
- CHARGE: each cycle with press=1, charge ← min(charge+1, CHARGE_MAX).
- CHARGE exit: on fall, latch target ← player_x + (charge<<GAIN_SHIFT) as a 12-bit value, latch start ← player_x, go to FLY.
- FLY: every STEP_DIV cycles, player_x += 1.
  - d = player_x − start, D = target − start.
  - player_y ← min(d, D−d).
  - When player_x reaches min(target, 1023), go to JUDGE with player_y=0.
  - If target > 1023, player_x stops at 1023.
- JUDGE, one cycle; all compares are 12-bit unsigned; intervals are half-open:
  - **Hit**: stage_x[1] ≤ target < stage_x[1]+stage_w[1]. Pulse hit and next_stage, score += 1 (wraps at 65535), latch off ← target − stage_x[1], go to SCROLL.
  - **Stay**: otherwise, if target < stage_x[0]+stage_w[0]. Go to READY; no score change.
  - **Miss**: otherwise, go to OVER.
- SCROLL, one cycle: player_x ← stage_x[0] + off, using the post-update stage_x[0]. Go to READY.
- OVER: game_over=1, player_x held. On rise, clear score and go to PLACE.
- `enable`=0 in any state: go to IDLE next cycle. `score` holds until the next IDLE→PLACE.
- Simultaneous rise and fall cannot occur. A press already high when READY is entered is ignored until a fresh rise.

## Timing
- Reset (`rst`=0 at posedge): state IDLE, all outputs 0, press_q 0, internal registers 0.
- Charge latency: N cycles of press=1 in CHARGE gives charge=min(N,CHARGE_MAX). Target is latched on the fall cycle.
- Flight: exactly (min(target,1023)−start)·STEP_DIV cycles in FLY.
- `generate_stage` updates its stage registers at the posedge after `next_stage`. SCROLL therefore samples them exactly one cycle after the JUDGE cycle.
- hit and next_stage are high for exactly one cycle and always together.

## Structure
- The shared package/`parameter.v` holds:
  - the state enum;
  - the STAGE0_X=60 constant, shared with `generate_stage`;
  - the coordinate width `X_W`=10.
- One sub-module is natural: `jump_flight`. It holds the step divider, the player_x stepping and the triangular player_y arc. Its inputs are start/target/go; its output is done.
- Judge, scoring and the FSM stay in `jump_judge`.

## Test plan
All cases use GAIN_SHIFT=1, STEP_DIV=1, stage0 (60,60) and stage1 (200,40).
- **Hit**: enable, PLACE → player_x=90. Hold press 60 cycles → target 210 → hit; score=1; next_stage pulses once. Drive stage0 (60,60) → player_x=70 after SCROLL.
- **Stay / edge**: hold 10 → target 110, no hit, player_x=110, READY. Then hold 45 → target 200 → hit (inclusive left edge).
- **Exclusive right edge / miss**: from 90, hold 75 → target 240 → OVER, game_over=1, score unchanged. A rise then clears score and gives player_x=90.
- **Saturation / clamp**: hold 400 cycles → charge=255, target 600 → miss. Use stage1 (900,100) and hold 255 with player_x 600 → target 1110, player_x clamps at 1023, miss.
- **Reset / enable mid-op**: assert rst low during FLY → all outputs 0 next cycle. Drop enable in CHARGE → IDLE, score held until re-enable.
- **Arc**: for the 210 jump, peak player_y=60 at d=60; player_y=0 at both ends; FLY lasts 120 cycles.
